// File: rtl/tournament_update_scheduler_if.sv
// Handshake bundle between fetch/retire, the tournament table port and the update scheduler.
// The slave modport is the scheduler's view; master is the surrounding pipeline/table.
interface tournament_update_scheduler_if #(
   parameter int FIFO_DEPTH = 4
);
   logic                          lookup_v;
   logic [31:0]                   lookup_pc;
   logic                          lookup_ready;
   logic                          upd_v;
   logic [31:0]                   upd_pc;
   logic                          upd_taken;
   logic                          upd_gcorrect;
   logic                          upd_lcorrect;
   logic                          upd_ready;
   logic                          tbl_en;
   logic                          tbl_we;
   logic [31:0]                   tbl_pc;
   logic                          tbl_taken;
   logic                          tbl_gcorrect;
   logic                          tbl_lcorrect;
   logic                          tbl_rd_taken;
   logic                          pred_v;
   logic                          pred_taken;
   logic [$clog2(FIFO_DEPTH):0]   q_count;

   modport slave (
      input  lookup_v, lookup_pc, upd_v, upd_pc, upd_taken, upd_gcorrect, upd_lcorrect,
             tbl_rd_taken,
      output lookup_ready, upd_ready, tbl_en, tbl_we, tbl_pc, tbl_taken, tbl_gcorrect,
             tbl_lcorrect, pred_v, pred_taken, q_count
   );

   modport master (
      output lookup_v, lookup_pc, upd_v, upd_pc, upd_taken, upd_gcorrect, upd_lcorrect,
             tbl_rd_taken,
      input  lookup_ready, upd_ready, tbl_en, tbl_we, tbl_pc, tbl_taken, tbl_gcorrect,
             tbl_lcorrect, pred_v, pred_taken, q_count
   );
endinterface

// File: rtl/tournament_update_scheduler.sv
// Shares the single tournament-table port between fetch lookups and queued retire updates,
// with lookup priority bounded by a starvation counter and a full-queue override.
module tournament_update_scheduler #(
   parameter int FIFO_DEPTH   = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                         clock,
   input  logic                         reset,
   tournament_update_scheduler_if.slave bus
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int SW = $clog2(STARVE_LIMIT);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT - 1);
   localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

   logic [31:0]           fifo_pc [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] fifo_taken;
   logic [FIFO_DEPTH-1:0] fifo_gc;
   logic [FIFO_DEPTH-1:0] fifo_lc;
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic [CW-1:0]         q_count;
   logic [SW-1:0]         starve_cnt;

   logic                  tbl_en_r;
   logic                  tbl_we_r;
   logic [31:0]           tbl_pc_r;
   logic                  tbl_taken_r;
   logic                  tbl_gc_r;
   logic                  tbl_lc_r;
   logic                  pred_v_r;

   logic                  q_empty;
   logic                  q_full;
   logic                  grant_upd;
   logic                  grant_lkp;
   logic                  push;

   // Arbitration looks only at registered occupancy, so an update pushed this cycle
   // cannot reach the table before the next one.
   always_comb begin
      q_empty   = (q_count == '0);
      q_full    = (q_count == FULL_COUNT);
      grant_upd = !q_empty && (q_full || (starve_cnt == STARVE_MAX) || !bus.lookup_v);
      grant_lkp = bus.lookup_v && !grant_upd;
      push      = bus.upd_v && !q_full && !reset;
   end

   assign bus.lookup_ready = grant_lkp && !reset;
   assign bus.upd_ready    = !q_full && !reset;
   assign bus.q_count      = q_count;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) fifo_pc[i] <= '0;
         fifo_taken  <= '0;
         fifo_gc     <= '0;
         fifo_lc     <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         q_count     <= '0;
         starve_cnt  <= '0;
         tbl_en_r    <= 1'b0;
         tbl_we_r    <= 1'b0;
         tbl_pc_r    <= '0;
         tbl_taken_r <= 1'b0;
         tbl_gc_r    <= 1'b0;
         tbl_lc_r    <= 1'b0;
         pred_v_r    <= 1'b0;
      end else begin
         if (push) begin
            fifo_pc[wr_ptr]    <= bus.upd_pc;
            fifo_taken[wr_ptr] <= bus.upd_taken;
            fifo_gc[wr_ptr]    <= bus.upd_gcorrect;
            fifo_lc[wr_ptr]    <= bus.upd_lcorrect;
            wr_ptr             <= wr_ptr + PW'(1);
         end
         if (grant_upd) rd_ptr <= rd_ptr + PW'(1);

         case ({push, grant_upd})
            2'b10:   q_count <= q_count + CW'(1);
            2'b01:   q_count <= q_count - CW'(1);
            default: q_count <= q_count;
         endcase

         if (grant_upd || q_empty)
            starve_cnt <= '0;
         else if (grant_lkp && (starve_cnt != STARVE_MAX))
            starve_cnt <= starve_cnt + SW'(1);

         tbl_en_r    <= grant_upd || grant_lkp;
         tbl_we_r    <= grant_upd;
         tbl_pc_r    <= grant_upd ? fifo_pc[rd_ptr] : (grant_lkp ? bus.lookup_pc : '0);
         tbl_taken_r <= grant_upd && fifo_taken[rd_ptr];
         tbl_gc_r    <= grant_upd && fifo_gc[rd_ptr];
         tbl_lc_r    <= grant_upd && fifo_lc[rd_ptr];

         // The table answers a read one cycle after it sees it.
         pred_v_r    <= tbl_en_r && !tbl_we_r;
      end
   end

   assign bus.tbl_en       = tbl_en_r;
   assign bus.tbl_we       = tbl_we_r;
   assign bus.tbl_pc       = tbl_pc_r;
   assign bus.tbl_taken    = tbl_taken_r;
   assign bus.tbl_gcorrect = tbl_gc_r;
   assign bus.tbl_lcorrect = tbl_lc_r;
   assign bus.pred_v       = pred_v_r;
   assign bus.pred_taken   = pred_v_r && bus.tbl_rd_taken;
endmodule

// File: tb/tb_tournament_update_scheduler.sv
// Bench for tournament_update_scheduler: directed scenarios with literal expectations plus a
// queue-based reference model compared against the DUT on every falling edge.
module tb_tournament_update_scheduler;
   localparam int FD = 4;
   localparam int SL = 8;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;

   tournament_update_scheduler_if #(.FIFO_DEPTH(FD)) bus ();

   tournament_update_scheduler #(.FIFO_DEPTH(FD), .STARVE_LIMIT(SL)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   function automatic logic pc_hash(input logic [31:0] pc);
      return pc[12] ^ pc[4];
   endfunction

   // Table stand-in: returns a PC-derived prediction the cycle after a read.
   always @(posedge clock)
      bus.tbl_rd_taken <= (bus.tbl_en && !bus.tbl_we) ? pc_hash(bus.tbl_pc) : 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   typedef struct {
      logic [31:0] pc;
      logic        t;
      logic        g;
      logic        l;
   } upd_t;

   upd_t        mq[$];
   upd_t        head;
   int          m_starve = 0;
   int          sz;
   logic        m_full, g_upd, g_lkp, n_pv, n_pt;
   logic        e_en = 0, e_we = 0, e_t = 0, e_g = 0, e_l = 0, e_pv = 0, e_pt = 0;
   logic [31:0] e_pc = 0;

   always @(negedge clock) begin
      if (reset) begin
         mq.delete();
         m_starve = 0;
         {e_en, e_we, e_t, e_g, e_l, e_pv, e_pt} = '0;
         e_pc = '0;
         check("m_rst_lookup_ready", bus.lookup_ready, 0);
         check("m_rst_upd_ready", bus.upd_ready, 0);
         check("m_rst_q_count", bus.q_count, 0);
         check("m_rst_tbl_en", bus.tbl_en, 0);
         check("m_rst_pred_v", bus.pred_v, 0);
         check("m_rst_pred_taken", bus.pred_taken, 0);
      end else begin
         sz     = mq.size();
         m_full = (sz == FD);
         g_upd  = (sz > 0) && (m_full || m_starve == SL - 1 || !bus.lookup_v);
         g_lkp  = bus.lookup_v && !g_upd;

         check("m_lookup_ready", bus.lookup_ready, g_lkp);
         check("m_upd_ready", bus.upd_ready, !m_full);
         check("m_q_count", bus.q_count, sz);
         check("m_tbl_en", bus.tbl_en, e_en);
         check("m_tbl_we", bus.tbl_we, e_we);
         check("m_tbl_pc", bus.tbl_pc, e_pc);
         check("m_tbl_taken", bus.tbl_taken, e_t);
         check("m_tbl_gcorrect", bus.tbl_gcorrect, e_g);
         check("m_tbl_lcorrect", bus.tbl_lcorrect, e_l);
         check("m_pred_v", bus.pred_v, e_pv);
         check("m_pred_taken", bus.pred_taken, e_pt);

         n_pv = e_en && !e_we;
         n_pt = n_pv && pc_hash(e_pc);
         e_pv = n_pv;
         e_pt = n_pt;
         if (g_upd) begin
            head = mq.pop_front();
            e_en = 1; e_we = 1; e_pc = head.pc; e_t = head.t; e_g = head.g; e_l = head.l;
         end else if (g_lkp) begin
            e_en = 1; e_we = 0; e_pc = bus.lookup_pc; e_t = 0; e_g = 0; e_l = 0;
         end else begin
            {e_en, e_we, e_t, e_g, e_l} = '0;
            e_pc = '0;
         end
         if (bus.upd_v && !m_full)
            mq.push_back('{pc: bus.upd_pc, t: bus.upd_taken, g: bus.upd_gcorrect,
                           l: bus.upd_lcorrect});
         if (g_upd || sz == 0)  m_starve = 0;
         else if (g_lkp)        m_starve = (m_starve + 1 > SL - 1) ? SL - 1 : m_starve + 1;
      end
   end

   initial begin
      int  n;
      bit  done;
      bus.lookup_v = 0; bus.lookup_pc = 0;
      bus.upd_v = 0; bus.upd_pc = 0; bus.upd_taken = 0; bus.upd_gcorrect = 0;
      bus.upd_lcorrect = 0;

      repeat (3) step();
      #1;
      check("rst_upd_ready", bus.upd_ready, 0);
      check("rst_lookup_ready", bus.lookup_ready, 0);
      step();
      reset = 0;
      #1;
      check("post_rst_upd_ready", bus.upd_ready, 1);

      // single lookup, empty queue
      step();
      bus.lookup_v = 1; bus.lookup_pc = 32'h1000;
      #1 check("lk_ready_c0", bus.lookup_ready, 1);
      step();
      bus.lookup_v = 0;
      #1;
      check("lk_tbl_en_c1", bus.tbl_en, 1);
      check("lk_tbl_we_c1", bus.tbl_we, 0);
      check("lk_tbl_pc_c1", bus.tbl_pc, 32'h1000);
      step();
      #1;
      check("lk_pred_v_c2", bus.pred_v, 1);
      check("lk_pred_taken_c2", bus.pred_taken, 1);

      // update on idle port
      repeat (2) step();
      bus.upd_v = 1; bus.upd_pc = 32'h2000;
      bus.upd_taken = 1; bus.upd_gcorrect = 0; bus.upd_lcorrect = 1;
      #1 check("up_ready_c0", bus.upd_ready, 1);
      step();
      bus.upd_v = 0;
      #1;
      check("up_q_count_c1", bus.q_count, 1);
      check("up_tbl_en_c1", bus.tbl_en, 0);
      step();
      #1;
      check("up_tbl_en_c2", bus.tbl_en, 1);
      check("up_tbl_we_c2", bus.tbl_we, 1);
      check("up_tbl_pc_c2", bus.tbl_pc, 32'h2000);
      check("up_tbl_taken_c2", bus.tbl_taken, 1);
      check("up_tbl_gc_c2", bus.tbl_gcorrect, 0);
      check("up_tbl_lc_c2", bus.tbl_lcorrect, 1);
      check("up_q_count_c2", bus.q_count, 0);

      // starvation bound
      step();
      bus.upd_v = 1; bus.upd_pc = 32'h3000;
      bus.upd_taken = 0; bus.upd_gcorrect = 1; bus.upd_lcorrect = 0;
      bus.lookup_v = 1; bus.lookup_pc = 32'h4000;
      step();
      bus.upd_v = 0; bus.lookup_pc = 32'h4004;
      #1;
      n = 0; done = 0;
      for (int i = 0; i < 20 && !done; i++) begin
         if (bus.lookup_ready) begin
            n++;
            step();
            bus.lookup_pc = bus.lookup_pc + 4;
            #1;
         end else begin
            done = 1;
         end
      end
      check("starve_lookups", n, 7);
      check("starve_upd_within_bound", done, 1);
      check("starve_q_count", bus.q_count, 1);
      step();
      bus.lookup_pc = bus.lookup_pc + 4;
      #1;
      check("starve_resume_ready", bus.lookup_ready, 1);
      check("starve_q_empty", bus.q_count, 0);
      check("starve_tbl_we", bus.tbl_we, 1);
      check("starve_tbl_pc", bus.tbl_pc, 32'h3000);
      bus.lookup_v = 0;
      step();

      // full queue with lookups pending
      step();
      bus.lookup_v = 1; bus.lookup_pc = 32'h8000;
      bus.upd_v = 1; bus.upd_pc = 32'h5000;
      bus.upd_taken = 1; bus.upd_gcorrect = 1; bus.upd_lcorrect = 1;
      for (int i = 0; i < 4; i++) begin
         #1 check("fill_upd_ready", bus.upd_ready, 1);
         step();
         bus.upd_pc = bus.upd_pc + 32'h10;
      end
      #1;
      check("full_upd_ready", bus.upd_ready, 0);
      check("full_q_count", bus.q_count, 4);
      check("full_lookup_ready", bus.lookup_ready, 0);
      step();
      #1;
      check("full_ready_back", bus.upd_ready, 1);
      check("full_q_after_pop", bus.q_count, 3);
      step();
      bus.upd_v = 0;
      #1 check("full_fifth_held", bus.q_count, 4);
      bus.lookup_v = 0;
      repeat (6) step();
      check("full_drained", bus.q_count, 0);

      // reset mid-operation
      bus.lookup_v = 1; bus.lookup_pc = 32'h6000;
      bus.upd_v = 1; bus.upd_pc = 32'h7000;
      step();
      bus.upd_pc = 32'h7010;
      step();
      bus.upd_pc = 32'h7020;
      step();
      bus.upd_v = 0;
      #1;
      check("rm_q_count", bus.q_count, 3);
      check("rm_lookup_ready", bus.lookup_ready, 1);
      step();
      check("rm_inflight_en", bus.tbl_en, 1);
      reset = 1;
      bus.lookup_v = 0;
      #1;
      check("rm_q_cleared", bus.q_count, 0);
      check("rm_pred_v", bus.pred_v, 0);
      check("rm_tbl_en", bus.tbl_en, 0);
      repeat (2) step();
      reset = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         #1 check("rm_no_pred_after", bus.pred_v, 0);
      end

      // mixed traffic against the model
      for (int i = 0; i < 300; i++) begin
         step();
         bus.lookup_v     = ($urandom_range(0, 3) != 0);
         bus.lookup_pc    = $urandom;
         bus.upd_v        = ($urandom_range(0, 2) == 0);
         bus.upd_pc       = $urandom;
         bus.upd_taken    = 1'($urandom_range(0, 1));
         bus.upd_gcorrect = 1'($urandom_range(0, 1));
         bus.upd_lcorrect = 1'($urandom_range(0, 1));
      end
      bus.lookup_v = 0;
      bus.upd_v = 0;
      repeat (8) step();
      check("final_q_empty", bus.q_count, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
